// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alu_pkg
//  Description : Shared opcode constants and response-buffer state encoding
//                for the shared-ALU request scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  // ALU opcodes as presented on req_op
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Single-entry response buffer occupancy
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first asserted
//                request at or above the pointer, wrapping modulo N.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant
);

  int   w_idx;
  logic w_found;

  // Walk the requests starting at the pointer; first hit wins, nothing when disabled
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(ptr) + k) % N;
      if (en && !w_found && req[w_idx[PW-1:0]]) begin
        grant[w_idx[PW-1:0]] = 1'b1;
        w_found              = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/simple_alu.sv
`default_nettype none
// ============================================================================
//  Module      : simple_alu
//  Description : Combinational 2-bit ALU producing a 4-bit result and a
//                carry/borrow/divide-by-zero flag from a 5-bit intermediate.
//  Revision    : 1.0  initial release
// ============================================================================
module simple_alu
  import alu_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] op,
  output logic [3:0] y,
  output logic       c
);

  logic [4:0] w_res;

  // Evaluate the selected operation into {c,y}; subtraction wraps mod 32 so
  // a borrow shows up in bit 4, divide-by-zero forces {1,0000}
  always_comb begin
    w_res = '0;
    case (op)
      OP_ADD:  w_res = {3'b000, a} + {3'b000, b};
      OP_SUB:  w_res = {3'b000, a} - {3'b000, b};
      OP_MUL:  w_res = {1'b0, {2'b00, a} * {2'b00, b}};
      OP_DIV: begin
        if (b != 2'b00) begin
          w_res = {3'b000, a / b};
        end else begin
          w_res = 5'b10000;
        end
      end
      default: w_res = '0;
    endcase
  end

  assign y = w_res[3:0];
  assign c = w_res[4];

endmodule : simple_alu
`default_nettype wire

// File: rtl/alu_req_sched.sv
`default_nettype none
// ============================================================================
//  Module      : alu_req_sched
//  Description : Round-robin scheduler sharing one 2-bit ALU among NUM_REQ
//                valid/ready requesters. Results land in a single-entry
//                response buffer tagged with the requester ID; accepted
//                divide-by-zero operations are counted with saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_req_sched
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ),
  parameter int ERR_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*NUM_REQ-1:0] req_a,
  input  logic [2*NUM_REQ-1:0] req_b,
  input  logic [2*NUM_REQ-1:0] req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_y,
  output logic                 rsp_c,
  output logic [IDW-1:0]       rsp_id,
  output logic [ERR_W-1:0]     err_cnt,
  output logic                 busy
);

  localparam logic [ERR_W-1:0] c_err_max = '1;
  localparam logic [IDW-1:0]   c_last_id = IDW'(NUM_REQ - 1);

  buf_state_t r_state;
  buf_state_t w_state_nxt;

  logic               w_can_issue;
  logic               w_xfer;
  logic               w_load;
  logic               w_rsp_valid;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     w_gidx;
  logic [1:0]         w_a;
  logic [1:0]         w_b;
  logic [1:0]         w_op;
  logic [3:0]         w_y;
  logic               w_c;
  logic               w_div0;

  logic [3:0]         r_y;
  logic               r_c;
  logic [IDW-1:0]     r_id;
  logic [ERR_W-1:0]   r_err;

  // A new op may enter whenever the buffer is empty or is being drained now
  assign w_can_issue = (r_state == ST_EMPTY) || rsp_ready;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .en    (w_can_issue),
    .grant (w_grant)
  );

  // Grant is already gated by can_issue, so it doubles as the ready vector
  assign req_ready = w_grant;
  assign w_xfer    = |(req_valid & w_grant);

  // Encode the one-hot grant and steer the winner's operands to the ALU
  always_comb begin
    w_gidx = '0;
    w_a    = '0;
    w_b    = '0;
    w_op   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gidx = IDW'(i);
        w_a    = req_a[2*i +: 2];
        w_b    = req_b[2*i +: 2];
        w_op   = req_op[2*i +: 2];
      end
    end
  end

  simple_alu u_alu (
    .a  (w_a),
    .b  (w_b),
    .op (w_op),
    .y  (w_y),
    .c  (w_c)
  );

  assign w_div0 = (w_op == OP_DIV) && (w_b == 2'b00);

  // Buffer state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Buffer next state: fill on transfer, drain only when nothing replaces it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_xfer) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (rsp_ready && !w_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Buffer outputs: occupancy flag and result-capture strobe
  always_comb begin
    w_rsp_valid = (r_state == ST_FULL);
    w_load      = w_xfer;
  end

  // Capture the ALU result and requester ID; overwrite happens with no bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y  <= '0;
      r_c  <= 1'b0;
      r_id <= '0;
    end else if (w_load) begin
      r_y  <= w_y;
      r_c  <= w_c;
      r_id <= w_gidx;
    end
  end

  // Move the round-robin pointer just past the requester that was served
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_gidx == c_last_id) ? '0 : w_gidx + IDW'(1);
    end
  end

  // Count accepted divide-by-zero ops, sticking at the maximum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= '0;
    end else if (w_xfer && w_div0 && (r_err != c_err_max)) begin
      r_err <= r_err + ERR_W'(1);
    end
  end

  assign rsp_valid = w_rsp_valid;
  assign rsp_y     = r_y;
  assign rsp_c     = r_c;
  assign rsp_id    = r_id;
  assign err_cnt   = r_err;
  assign busy      = w_rsp_valid | (|req_valid);

endmodule : alu_req_sched
`default_nettype wire

// File: tb/tb_alu_req_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_req_sched
//  Description : Self-checking bench for alu_req_sched: random and directed
//                requesters, a reference model of the round-robin/buffer
//                rules feeding an expected-response queue, and a monitor
//                that checks every presented response against that queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_req_sched;

  localparam int N     = 2;
  localparam int IDW   = 1;
  localparam int ERR_W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_a;
  logic [2*N-1:0] req_b;
  logic [2*N-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [3:0]     rsp_y;
  logic           rsp_c;
  logic [IDW-1:0] rsp_id;
  logic [ERR_W-1:0] err_cnt;
  logic           busy;

  typedef struct packed {
    logic [3:0]     y;
    logic           c;
    logic [IDW-1:0] id;
  } rsp_t;

  rsp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int           m_ptr  = 0;
  bit           m_full = 1'b0;
  int           m_err  = 0;
  logic [N-1:0] acc    = '0;
  logic [N-1:0] p_pend = '0;
  logic [5:0]   p_ops [N];

  always #5 clk = ~clk;

  alu_req_sched #(
    .NUM_REQ (N),
    .ERR_W   (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_c     (rsp_c),
    .rsp_id    (rsp_id),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference for the ALU, straight from the operation definitions
  function automatic rsp_t model_op(input int a, input int b, input int op, input int id);
    rsp_t r;
    int   y;
    int   c;
    y = 0;
    c = 0;
    case (op)
      0: y = a + b;
      1: begin
        y = a - b;
        c = (y < 0) ? 1 : 0;
        y = (y + 16) % 16;
      end
      2: y = a * b;
      default: begin
        if (b == 0) begin
          y = 0;
          c = 1;
        end else begin
          y = a / b;
        end
      end
    endcase
    r.y  = 4'(y);
    r.c  = c[0];
    r.id = IDW'(id);
    return r;
  endfunction

  // Reference model: expected grants, buffer occupancy, error count; pushes expectations
  always @(negedge clk) begin : model
    int           g;
    int           idx;
    bit           can;
    logic [N-1:0] eg;
    acc = '0;
    if (!rst_n) begin
      m_ptr  = 0;
      m_full = 1'b0;
      m_err  = 0;
      p_pend = '0;
      exp_q.delete();
    end else begin
      chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_full || (req_valid != '0)));
      for (int i = 0; i < N; i++) begin
        if (p_pend[i]) begin
          chk("hold_stable", {25'd0, req_valid[i], req_a[2*i +: 2], req_b[2*i +: 2], req_op[2*i +: 2]},
              {25'd0, 1'b1, p_ops[i]});
        end
      end
      can = !m_full || rsp_ready;
      g   = -1;
      eg  = '0;
      if (can) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) eg[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(eg));
      if (g >= 0) begin
        exp_q.push_back(model_op(int'(req_a[2*g +: 2]), int'(req_b[2*g +: 2]),
                                 int'(req_op[2*g +: 2]), g));
        if (req_op[2*g +: 2] == 2'b11 && req_b[2*g +: 2] == 2'b00 && m_err < 255) m_err++;
        m_ptr  = (g + 1) % N;
        m_full = 1'b1;
        acc[g] = 1'b1;
      end else if (rsp_ready) begin
        m_full = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        p_pend[i] = req_valid[i] && !acc[i];
        p_ops[i]  = {req_a[2*i +: 2], req_b[2*i +: 2], req_op[2*i +: 2]};
      end
    end
  end

  // Monitor: every cycle a response is presented it must match the queue head
  always @(negedge clk) begin : monitor
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got y=%0h c=%0b id=%0d expected none", rsp_y, rsp_c, rsp_id);
      end else begin
        chk("rsp_data", 32'({rsp_y, rsp_c, rsp_id}), 32'(exp_q[0]));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] op);
    req_valid[i]      = v;
    req_a[2*i +: 2]   = a;
    req_b[2*i +: 2]   = b;
    req_op[2*i +: 2]  = op;
  endtask

  // Idle or just-accepted requesters may start a new op; pending ones hold
  task automatic drive_rand(input int pct, input bit div0);
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || acc[i]) begin
        if ($urandom_range(99) < 32'(pct)) begin
          set_req(i, 1'b1, 2'($urandom), div0 ? 2'b00 : 2'($urandom), div0 ? 2'b11 : 2'($urandom));
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic issue(input int i, input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
    bit done;
    done = 1'b0;
    set_req(i, 1'b1, a, b, op);
    for (int t = 0; t < 20 && !done; t++) begin
      cycle();
      if (acc[i]) begin
        done         = 1'b1;
        req_valid[i] = 1'b0;
      end
    end
    chk("issue_accept", 32'(done), 32'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic quiesce();
    for (int t = 0; t < 50; t++) begin
      cycle();
      drive_rand(0, 1'b0);
      if (req_valid == '0) break;
    end
    chk("quiesce", 32'(req_valid), 32'd0);
    repeat (2) cycle();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_y", 32'(rsp_y), 32'd0);
    chk("reset_rsp_c", 32'(rsp_c), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);

    // single add
    cycle();
    issue(0, 2'd3, 2'd2, 2'b00);
    @(negedge clk);
    chk("add_valid", 32'(rsp_valid), 32'd1);
    chk("add_y", 32'(rsp_y), 32'd5);
    chk("add_c", 32'(rsp_c), 32'd0);
    chk("add_id", 32'(rsp_id), 32'd0);
    cycle();

    // fairness: both requesters always valid
    repeat (40) begin
      drive_rand(100, 1'b0);
      cycle();
    end

    // backpressure with full buffer, then drain-and-issue
    drive_rand(100, 1'b0);
    cycle();
    rsp_ready = 1'b0;
    repeat (5) begin
      drive_rand(100, 1'b0);
      cycle();
    end
    rsp_ready = 1'b1;
    repeat (6) begin
      drive_rand(100, 1'b0);
      cycle();
    end
    quiesce();

    // sub borrow and multiply
    issue(0, 2'd1, 2'd2, 2'b01);
    @(negedge clk);
    chk("sub_y", 32'(rsp_y), 32'hF);
    chk("sub_c", 32'(rsp_c), 32'd1);
    cycle();
    issue(1, 2'd3, 2'd3, 2'b10);
    @(negedge clk);
    chk("mul_y", 32'(rsp_y), 32'd9);
    chk("mul_c", 32'(rsp_c), 32'd0);
    chk("mul_id", 32'(rsp_id), 32'd1);
    cycle();

    // divide-by-zero flood, err_cnt must saturate
    repeat (320) begin
      drive_rand(100, 1'b1);
      cycle();
    end
    quiesce();
    @(negedge clk);
    chk("err_saturated", 32'(err_cnt), 32'd255);
    cycle();
    issue(1, 2'd3, 2'd2, 2'b11);
    @(negedge clk);
    chk("div_y", 32'(rsp_y), 32'd1);
    chk("div_c", 32'(rsp_c), 32'd0);
    cycle();

    // random traffic with random backpressure
    repeat (1500) begin
      drive_rand(60, 1'b0);
      rsp_ready = ($urandom_range(3) != 0);
      cycle();
    end
    rsp_ready = 1'b1;
    quiesce();

    // reset while full and stalled
    rsp_ready = 1'b0;
    issue(0, 2'd2, 2'd1, 2'b00);
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
    cycle();
    set_req(0, 1'b1, 2'd1, 2'd1, 2'b00);
    set_req(1, 1'b1, 2'd2, 2'd2, 2'b00);
    @(negedge clk);
    chk("rst_first_grant", 32'(req_ready), 32'd1);
    cycle();
    quiesce();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_req_sched
`default_nettype wire
